multiport_fifo: RTL and testbench

- Circular FIFO with N-lane enqueue and M-lane dequeue per cycle, for superscalar front-end and dispatch buffering in the out-of-order core (fetch queue, decode-to-rename, LSQ feeds).
- Read side is first-word-fall-through: the oldest entries are presented combinationally from storage.
- Adds features the single-port FIFO lacks: flush, occupancy outputs, almost-full, an optional overwrite-oldest mode, and sticky error flags.

---
 rtl/multiport_fifo.sv | 116 +++++++++++
 tb/tb_multiport_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_fifo.sv
// Circular FIFO with WR_PORTS enqueue lanes and RD_PORTS first-word-fall-through dequeue lanes.
// Provides flush, occupancy outputs, almost-full, an optional overwrite-oldest mode and sticky error flags.
module multiport_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int WR_PORTS     = 2,
    parameter int RD_PORTS     = 2,
    parameter int OVERWRITE    = 0,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [$clog2(WR_PORTS+1)-1:0]     wr_cnt,
    input  logic [WR_PORTS*DATA_W-1:0]        wr_data,
    input  logic [$clog2(RD_PORTS+1)-1:0]     rd_cnt,
    output logic [$clog2(RD_PORTS+1)-1:0]     rd_avail,
    output logic [RD_PORTS*DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [$clog2(DEPTH+1)-1:0]        free_slots,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              overflow_err,
    output logic                              underflow_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WC_W   = $clog2(WR_PORTS + 1);
    localparam int RC_W   = $clog2(RD_PORTS + 1);
    localparam int CALC_W = CNT_W + 2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [CALC_W-1:0] cnt_x, wr_x, rd_x, avail_x;
    logic [CALC_W-1:0] pop_x, push_x, sum_x, excess_x, next_x;
    logic              accept, ovf_now, unf_now;

    always_comb begin
        cnt_x   = CALC_W'(count);
        wr_x    = CALC_W'(wr_cnt);
        rd_x    = CALC_W'(rd_cnt);
        avail_x = CALC_W'(rd_avail);
        unf_now = rd_x > avail_x;
        pop_x   = unf_now ? avail_x : rd_x;
        sum_x   = cnt_x - pop_x + wr_x;
        if (OVERWRITE != 0) begin
            // Entries pushed past capacity evict the oldest ones by advancing head.
            accept   = 1'b1;
            ovf_now  = 1'b0;
            push_x   = wr_x;
            excess_x = (sum_x > CALC_W'(DEPTH)) ? sum_x - CALC_W'(DEPTH) : '0;
        end else begin
            // Only pre-pop free space counts; the write is all-or-nothing.
            accept   = wr_x <= CALC_W'(free_slots);
            ovf_now  = !accept;
            push_x   = accept ? wr_x : '0;
            excess_x = '0;
        end
        next_x = cnt_x - pop_x + push_x - excess_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (ovf_now) overflow_err  <= 1'b1;
            if (unf_now) underflow_err <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(pop_x + excess_x);
                tail  <= tail + PTR_W'(push_x);
                count <= CNT_W'(next_x);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && accept) begin
            for (int unsigned k = 0; k < WR_PORTS; k++) begin
                if (k < 32'(wr_cnt))
                    mem[tail + PTR_W'(k)] <= wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_avail    = (count >= CNT_W'(RD_PORTS)) ? RC_W'(RD_PORTS) : RC_W'(count);
        free_slots  = CNT_W'(DEPTH) - count;
        full        = count == CNT_W'(DEPTH);
        empty       = count == '0;
        almost_full = CALC_W'(count) >= CALC_W'(AFULL_THRESH);
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned j = 0; j < RD_PORTS; j++) begin
            if (j < 32'(rd_avail))
                rd_data[j*DATA_W +: DATA_W] = mem[head + PTR_W'(j)];
        end
    end

    a_wr_cnt_legal: assert property (@(posedge clk) disable iff (reset) wr_cnt <= WC_W'(WR_PORTS));
    a_rd_cnt_legal: assert property (@(posedge clk) disable iff (reset) rd_cnt <= RC_W'(RD_PORTS));

endmodule

// File: tb/tb_multiport_fifo.sv
// Randomized and directed bench for multiport_fifo, instance 0 rejecting overflow and instance 1 overwriting.
// Expected values come from a queue-based model of the FIFO rules.
module tb_multiport_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        flush0, flush1;
    logic [1:0]  wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1;
    logic [63:0] wr_data0, wr_data1;
    logic [1:0]  rd_avail0, rd_avail1;
    logic [63:0] rd_data0, rd_data1;
    logic [2:0]  count0, count1, free0, free1;
    logic        full0, full1, empty0, empty1, af0, af1, ovf0, ovf1, unf0, unf1;

    multiport_fifo #(.DATA_W(32), .DEPTH(4), .WR_PORTS(2), .RD_PORTS(2), .OVERWRITE(0), .AFULL_THRESH(3)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .wr_cnt(wr_cnt0), .wr_data(wr_data0), .rd_cnt(rd_cnt0),
        .rd_avail(rd_avail0), .rd_data(rd_data0), .count(count0), .free_slots(free0), .full(full0),
        .empty(empty0), .almost_full(af0), .overflow_err(ovf0), .underflow_err(unf0));

    multiport_fifo #(.DATA_W(32), .DEPTH(4), .WR_PORTS(2), .RD_PORTS(2), .OVERWRITE(1), .AFULL_THRESH(3)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .wr_cnt(wr_cnt1), .wr_data(wr_data1), .rd_cnt(rd_cnt1),
        .rd_avail(rd_avail1), .rd_data(rd_data1), .count(count1), .free_slots(free1), .full(full1),
        .empty(empty1), .almost_full(af1), .overflow_err(ovf1), .underflow_err(unf1));

    typedef struct packed {
        logic [2:0]  count;
        logic [2:0]  free_slots;
        logic        full;
        logic        empty;
        logic        almost_full;
        logic [1:0]  rd_avail;
        logic [63:0] rd_data;
        logic        ovf;
        logic        unf;
    } st_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          movf [2];
    bit          munf [2];

    localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
    localparam logic [31:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;

    function automatic st_t observe(int m);
        st_t o;
        if (m == 0) o = '{count0, free0, full0, empty0, af0, rd_avail0, rd_data0, ovf0, unf0};
        else        o = '{count1, free1, full1, empty1, af1, rd_avail1, rd_data1, ovf1, unf1};
        return o;
    endfunction

    function automatic st_t expect_st(int m);
        st_t e;
        logic [31:0] q[$];
        int n;
        q = (m == 0) ? q0 : q1;
        n = q.size();
        e.count       = 3'(n);
        e.free_slots  = 3'(4 - n);
        e.full        = (n == 4);
        e.empty       = (n == 0);
        e.almost_full = (n >= 3);
        e.rd_avail    = 2'((n > 2) ? 2 : n);
        e.rd_data     = '0;
        if (n > 0) e.rd_data[31:0]  = q[0];
        if (n > 1) e.rd_data[63:32] = q[1];
        e.ovf = movf[m];
        e.unf = munf[m];
        return e;
    endfunction

    function automatic void model_step(int m, bit fl, int wc, logic [31:0] a, logic [31:0] b, int rc);
        logic [31:0] q[$];
        int avail, pop;
        bit acc;
        q = (m == 0) ? q0 : q1;
        avail = (q.size() > 2) ? 2 : q.size();
        pop = rc;
        if (rc > avail) begin
            munf[m] = 1'b1;
            pop = avail;
        end
        acc = 1'b1;
        if (m == 0 && wc > 4 - q.size()) begin
            acc = 1'b0;
            movf[m] = 1'b1;
        end
        if (fl) begin
            q.delete();
        end else begin
            repeat (pop) void'(q.pop_front());
            if (acc && wc > 0) q.push_back(a);
            if (acc && wc > 1) q.push_back(b);
            while (q.size() > 4) void'(q.pop_front());
        end
        if (m == 0) q0 = q; else q1 = q;
    endfunction

    task automatic set_idle();
        flush0 = 1'b0; wr_cnt0 = '0; wr_data0 = '0; rd_cnt0 = '0;
        flush1 = 1'b0; wr_cnt1 = '0; wr_data1 = '0; rd_cnt1 = '0;
    endtask

    task automatic drive(input int m, input bit fl, input int wc, input logic [31:0] a,
                         input logic [31:0] b, input int rc);
        set_idle();
        if (m == 0) begin
            flush0 = fl; wr_cnt0 = 2'(wc); wr_data0 = {b, a}; rd_cnt0 = 2'(rc);
        end else begin
            flush1 = fl; wr_cnt1 = 2'(wc); wr_data1 = {b, a}; rd_cnt1 = 2'(rc);
        end
        @(posedge clk);
        model_step(m, fl, wc, a, b, rc);
        #1;
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        q0.delete(); q1.delete();
        movf[0] = 0; movf[1] = 0; munf[0] = 0; munf[1] = 0;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        st_t o, e;
        do_reset();
        e = '{3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0};
        for (int m = 0; m < 2; m++) begin
            o = observe(m);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %h expected %h", m, o, e);
            end
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        drive(0, 0, 2, A, B, 0);
        checks++;
        if (count0 !== 3'd2 || af0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_half: count=%0d af=%b expected count=2 af=0", count0, af0);
        end
        drive(0, 0, 2, C, D, 0);
        checks++;
        if (count0 !== 3'd4 || full0 !== 1'b1 || af0 !== 1'b1 || free0 !== 3'd0) begin
            errors++;
            $display("FAIL fill_full: count=%0d full=%b af=%b free=%0d expected 4 1 1 0", count0, full0, af0, free0);
        end
        checks++;
        if (rd_data0 !== {B, A} || rd_avail0 !== 2'd2) begin
            errors++;
            $display("FAIL fill_head: rd_data=%h avail=%0d expected %h 2", rd_data0, rd_avail0, {B, A});
        end
    endtask

    task automatic test_overflow_pop();
        drive(0, 0, 1, E, 32'h0, 2);
        checks++;
        if (ovf0 !== 1'b1 || count0 !== 3'd2 || rd_data0 !== {D, C} || unf0 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pop: ovf=%b count=%0d rd_data=%h unf=%b expected 1 2 %h 0",
                     ovf0, count0, rd_data0, {D, C}, unf0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        do_reset();
        drive(0, 0, 2, 32'd0, 32'd1, 0);
        for (int k = 1; k < 10; k++) begin
            got.push_back(rd_data0[31:0]);
            got.push_back(rd_data0[63:32]);
            drive(0, 0, 2, 32'(2 * k), 32'(2 * k + 1), 2);
        end
        got.push_back(rd_data0[31:0]);
        got.push_back(rd_data0[63:32]);
        drive(0, 0, 0, 32'h0, 32'h0, 2);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (got[i] !== 32'(i)) begin
                errors++;
                $display("FAIL stream_order[%0d]: got %0d expected %0d", i, got[i], i);
            end
        end
        checks++;
        if (empty0 !== 1'b1 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: empty=%b ovf=%b unf=%b expected 1 0 0", empty0, ovf0, unf0);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 1, C, 32'h0, 0);
        checks++;
        if (rd_avail0 !== 2'd1 || rd_data0 !== {32'h0, C}) begin
            errors++;
            $display("FAIL single_entry: avail=%0d rd_data=%h expected 1 %h", rd_avail0, rd_data0, {32'h0, C});
        end
        drive(0, 0, 0, 32'h0, 32'h0, 2);
        checks++;
        if (empty0 !== 1'b1 || count0 !== 3'd0 || unf0 !== 1'b1 || rd_data0 !== 64'h0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL underflow: empty=%b count=%0d unf=%b rd_data=%h ovf=%b expected 1 0 1 0 0",
                     empty0, count0, unf0, rd_data0, ovf0);
        end
    endtask

    task automatic test_overwrite();
        do_reset();
        drive(1, 0, 2, A, B, 0);
        drive(1, 0, 2, C, D, 0);
        drive(1, 0, 2, E, F, 0);
        checks++;
        if (count1 !== 3'd4 || rd_data1 !== {D, C} || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL overwrite_evict: count=%0d rd_data=%h ovf=%b expected 4 %h 0", count1, rd_data1, ovf1, {D, C});
        end
        drive(1, 0, 0, 32'h0, 32'h0, 2);
        checks++;
        if (count1 !== 3'd2 || rd_data1 !== {F, E}) begin
            errors++;
            $display("FAIL overwrite_pop1: count=%0d rd_data=%h expected 2 %h", count1, rd_data1, {F, E});
        end
        drive(1, 0, 0, 32'h0, 32'h0, 2);
        checks++;
        if (empty1 !== 1'b1 || ovf1 !== 1'b0 || unf1 !== 1'b0) begin
            errors++;
            $display("FAIL overwrite_pop2: empty=%b ovf=%b unf=%b expected 1 0 0", empty1, ovf1, unf1);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 0, 2, A, B, 0);
        drive(0, 0, 1, C, 32'h0, 0);
        checks++;
        if (count0 !== 3'd3 || af0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: count=%0d af=%b expected 3 1", count0, af0);
        end
        drive(0, 1, 1, D, 32'h0, 0);
        checks++;
        if (count0 !== 3'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0 || rd_data0 !== 64'h0) begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b ovf=%b rd_data=%h expected 0 1 0 0", count0, empty0, ovf0, rd_data0);
        end
        drive(0, 1, 0, 32'h0, 32'h0, 2);
        drive(0, 0, 2, A, B, 0);
        drive(0, 0, 2, C, D, 0);
        drive(0, 0, 1, E, 32'h0, 0);
        drive(0, 1, 0, 32'h0, 32'h0, 0);
        checks++;
        if (unf0 !== 1'b1 || ovf0 !== 1'b1 || empty0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_flags: unf=%b ovf=%b empty=%b expected 1 1 1", unf0, ovf0, empty0);
        end
        do_reset();
        checks++;
        if (unf0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_flags: unf=%b ovf=%b expected 0 0", unf0, ovf0);
        end
    endtask

    task automatic test_random();
        st_t o, e;
        int m, wc, rc;
        bit fl;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                m  = int'($urandom_range(0, 1));
                fl = ($urandom_range(0, 15) == 0);
                wc = int'($urandom_range(0, 2));
                rc = int'($urandom_range(0, 2));
                drive(m, fl, wc, $urandom, $urandom, rc);
            end
            for (int d = 0; d < 2; d++) begin
                o = observe(d);
                e = expect_st(d);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d: got %h expected %h", it, d, o, e);
                end
            end
        end
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        test_fill_full();
        test_overflow_pop();
        test_back_to_back();
        test_underflow();
        test_overwrite();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
